// File: rtl/debounce_bank_if.sv
// Signal bundle between a debounce bank and its user: raw switch inputs and
// enable towards the bank, debounced levels and edge pulses back out.
interface debounce_bank_if #(
    parameter int CHANNELS = 4
);
    logic                enable;
    logic [CHANNELS-1:0] D;
    logic [CHANNELS-1:0] Q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                changed;

    modport master (
        output enable, D,
        input  Q, rise, fall, changed
    );

    modport slave (
        input  enable, D,
        output Q, rise, fall, changed
    );
endinterface

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers. Each channel is synchronised, then
// sampled on a shared prescaled tick; the debounced level flips only after
// FILTER_LEN consecutive ticks disagree with it, and a registered one-clock
// rise/fall pulse marks each flip.
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int PRESCALE    = 1,
    parameter int INIT_LEVEL  = 0
) (
    input  logic              clk,
    input  logic              reset,
    debounce_bank_if.slave    bus
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic          INIT_BIT = (INIT_LEVEL != 0);

    logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
    logic [CHANNELS-1:0] synced;
    logic [PW-1:0]       pre_cnt;
    logic                tick;
    logic [CW-1:0]       run_cnt [CHANNELS];
    logic [CW-1:0]       run_nxt [CHANNELS];
    logic [CHANNELS-1:0] flip;
    logic [CHANNELS-1:0] q_r;
    logic [CHANNELS-1:0] rise_r;
    logic [CHANNELS-1:0] fall_r;
    logic                changed_r;

    // Next run length: any agreeing sample restarts the run, and the final
    // disagreeing sample (the one that flips Q) also returns it to zero, so
    // the counter never climbs past FILTER_LEN-1.
    function automatic logic [CW-1:0] run_step(input logic [CW-1:0] cnt,
                                               input logic          differ);
        if (!differ || cnt == RUN_LAST) begin
            return '0;
        end
        return cnt + CW'(1);
    endfunction

    assign synced = sync_p[SYNC_STAGES-1];
    assign tick   = bus.enable && (pre_cnt == PRE_LAST);

    // Synchronizer chain: shifts every clock, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p[s] <= {CHANNELS{INIT_BIT}};
            end
        end else begin
            sync_p[0] <= bus.D;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
        end
    end

    // Sample-rate prescaler: wraps at PRESCALE-1 and holds while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (bus.enable) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    // Per-channel run evaluation on a tick: decide next run length and flips.
    always_comb begin
        flip = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            run_nxt[c] = run_cnt[c];
            if (tick) begin
                run_nxt[c] = run_step(run_cnt[c], synced[c] ^ q_r[c]);
                flip[c]    = (synced[c] ^ q_r[c]) && (run_cnt[c] == RUN_LAST);
            end
        end
    end

    // Run counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                run_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                run_cnt[c] <= run_nxt[c];
            end
        end
    end

    // Debounced level and edge pulses, registered together so they align.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r       <= {CHANNELS{INIT_BIT}};
            rise_r    <= '0;
            fall_r    <= '0;
            changed_r <= 1'b0;
        end else begin
            q_r       <= q_r ^ flip;
            rise_r    <= flip & ~q_r;
            fall_r    <= flip & q_r;
            changed_r <= |flip;
        end
    end

    assign bus.Q       = q_r;
    assign bus.rise    = rise_r;
    assign bus.fall    = fall_r;
    assign bus.changed = changed_r;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: default-parameter instance checked every clock
// against a sample-window model, plus a PRESCALE=3 instance with directed
// expectations.
module tb_debounce_bank;

    localparam int S  = 2;
    localparam int FL = 4;
    localparam int P  = 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   armed;

    debounce_bank_if #(.CHANNELS(4)) bus ();
    debounce_bank_if #(.CHANNELS(4)) bus3 ();

    debounce_bank #(
        .CHANNELS(4), .SYNC_STAGES(S), .FILTER_LEN(FL), .PRESCALE(P), .INIT_LEVEL(0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    debounce_bank #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(4), .PRESCALE(3), .INIT_LEVEL(0)
    ) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: input D seen through an S-deep delay line; each channel keeps the
    // tick samples taken since its last flip, and flips once the most recent
    // FL of them all oppose the current level.
    logic [3:0]  dq[$];
    logic [3:0]  m_q, m_rise, m_fall, m_syn;
    logic        m_chg, m_tick, m_ok;
    int          en_cnt;
    int          nsamp[4];
    logic [31:0] hist[4];

    always @(posedge clk) begin
        if (reset) begin
            m_q = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
            dq.delete();
            for (int i = 0; i < S; i++) dq.push_front(4'b0000);
            en_cnt = 0;
            for (int c = 0; c < 4; c++) begin nsamp[c] = 0; hist[c] = '0; end
        end else begin
            m_syn  = dq[S-1];
            m_tick = bus.enable && ((en_cnt % P) == P - 1);
            if (bus.enable) en_cnt++;
            m_rise = '0; m_fall = '0;
            if (m_tick) begin
                for (int c = 0; c < 4; c++) begin
                    hist[c] = {hist[c][30:0], m_syn[c]};
                    nsamp[c]++;
                    m_ok = (nsamp[c] >= FL);
                    for (int k = 0; k < FL; k++)
                        if (hist[c][k] == m_q[c]) m_ok = 1'b0;
                    if (m_ok) begin
                        if (m_q[c]) m_fall[c] = 1'b1; else m_rise[c] = 1'b1;
                        m_q[c]   = ~m_q[c];
                        nsamp[c] = 0;
                        hist[c]  = '0;
                    end
                end
            end
            m_chg = |(m_rise | m_fall);
            dq.push_front(bus.D);
            void'(dq.pop_back());
        end
    end

    // Every-cycle comparison of the default instance against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("model_Q", bus.Q, m_q);
            chk("model_rise", bus.rise, m_rise);
            chk("model_fall", bus.fall, m_fall);
            chk("model_changed", {3'b000, bus.changed}, {3'b000, m_chg});
        end
    end

    typedef struct { logic [3:0] d; logic en; int hold; } vec_t;
    vec_t tbl[7];

    initial begin
        checks = 0; errors = 0; armed = 0;
        reset = 1'b1;
        bus.enable = 1'b1; bus.D = 4'b0000;
        bus3.enable = 1'b1; bus3.D = 4'b0000;
        @(posedge clk);
        #1 armed = 1;
        step(2);
        chk("reset_Q", bus.Q, 4'b0000);
        chk("reset_rise", bus.rise, 4'b0000);
        chk("reset_changed", {3'b000, bus.changed}, 4'b0000);

        // Single channel rise, D held before the first non-reset edge.
        reset = 1'b0; bus.D = 4'b0001;
        step(5);
        chk("lat_Q_before", bus.Q, 4'b0000);
        step(1);
        chk("lat_Q", bus.Q, 4'b0001);
        chk("lat_rise", bus.rise, 4'b0001);
        chk("lat_fall", bus.fall, 4'b0000);
        chk("lat_changed", {3'b000, bus.changed}, 4'b0001);
        step(1);
        chk("lat_rise_end", bus.rise, 4'b0000);
        chk("lat_changed_end", {3'b000, bus.changed}, 4'b0000);

        // Simultaneous fall on ch0 and rise on ch2.
        bus.D = 4'b0100;
        step(5);
        chk("simul_Q_before", bus.Q, 4'b0001);
        step(1);
        chk("simul_Q", bus.Q, 4'b0100);
        chk("simul_fall", bus.fall, 4'b0001);
        chk("simul_rise", bus.rise, 4'b0100);
        chk("simul_changed", {3'b000, bus.changed}, 4'b0001);
        step(1);

        // Bounce on ch1: 3 high, 1 low, then high.
        bus.D = 4'b0110; step(3);
        bus.D = 4'b0100; step(1);
        bus.D = 4'b0110; step(5);
        chk("bounce_Q_hold", bus.Q, 4'b0100);
        step(1);
        chk("bounce_Q", bus.Q, 4'b0110);
        chk("bounce_rise", bus.rise, 4'b0010);

        // Enable dropped after two counted samples on ch3.
        bus.D = 4'b1110; step(4);
        bus.enable = 1'b0; step(10);
        chk("frozen_Q", bus.Q, 4'b0110);
        bus.enable = 1'b1; step(1);
        chk("resume_Q_hold", bus.Q, 4'b0110);
        step(1);
        chk("resume_Q", bus.Q, 4'b1110);
        chk("resume_rise", bus.rise, 4'b1000);

        // All high, then a one-clock reset pulse.
        bus.D = 4'b1111; step(6);
        chk("all_Q", bus.Q, 4'b1111);
        reset = 1'b1; step(1);
        chk("rstpulse_Q", bus.Q, 4'b0000);
        chk("rstpulse_fall", bus.fall, 4'b0000);
        reset = 1'b0; step(5);
        chk("rerise_Q_before", bus.Q, 4'b0000);
        step(1);
        chk("rerise_Q", bus.Q, 4'b1111);
        chk("rerise_rise", bus.rise, 4'b1111);

        // Reset mid-run discards a pending rise.
        reset = 1'b1; bus.D = 4'b0000; step(1);
        reset = 1'b0; bus.D = 4'b1111; step(4);
        reset = 1'b1; bus.D = 4'b0000; step(1);
        reset = 1'b0; step(8);
        chk("midrun_Q", bus.Q, 4'b0000);

        // Mixed directed patterns, model-checked each clock.
        tbl[0] = '{4'b1010, 1'b1, 7};
        tbl[1] = '{4'b1000, 1'b1, 2};
        tbl[2] = '{4'b0101, 1'b0, 3};
        tbl[3] = '{4'b0101, 1'b1, 9};
        tbl[4] = '{4'b0011, 1'b1, 1};
        tbl[5] = '{4'b1111, 1'b1, 8};
        tbl[6] = '{4'b0000, 1'b1, 8};
        for (int i = 0; i < 7; i++) begin
            bus.D = tbl[i].d; bus.enable = tbl[i].en;
            step(tbl[i].hold);
        end
        bus.enable = 1'b1;

        // PRESCALE=3 instance: ticks at edges 2,5,8,11 after release.
        reset = 1'b1; step(1);
        bus.D = 4'b0000; bus3.D = 4'b0001; reset = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            step(1);
            chk($sformatf("pre3_Q_e%0d", k), bus3.Q, (k >= 11) ? 4'b0001 : 4'b0000);
            chk($sformatf("pre3_rise_e%0d", k), bus3.rise, (k == 11) ? 4'b0001 : 4'b0000);
        end

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel (>=1).
REQ-003 Parameter FILTER_LEN, default 4: consecutive agreeing samples required to change output (>=1).
REQ-004 Parameter PRESCALE, default 1: clocks per sample tick (>=1; 1 = sample every clock).
REQ-005 Parameter INIT_LEVEL, default 0: reset level of synchronizers and Q (0 or 1, applied to all channels).
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  1 = filtering active; 0 = freeze prescaler, counters, Q.
REQ-009 D  input  CHANNELS  raw asynchronous switch inputs.
REQ-010 Q  output  CHANNELS  debounced levels, registered.
REQ-011 rise  output  CHANNELS  one-clock pulse per channel when Q goes 0->1, registered.
REQ-012 fall  output  CHANNELS  one-clock pulse per channel when Q goes 1->0, registered.
REQ-013 changed  output  1  registered OR of rise|fall across channels, same cycle as the pulses.

Function
REQ-014 Each channel SHALL pass D through SYNC_STAGES flops; synchronizers shift every clock regardless of enable.
REQ-015 Prescaler counter SHALL count 0..PRESCALE-1 and wrap to 0; tick = (count == PRESCALE-1) and enable; counter advances only while enable=1.
REQ-016 Each channel SHALL hold a run counter of width clog2(FILTER_LEN+1), saturating, never exceeding FILTER_LEN-1.
REQ-017 On a tick, a channel whose synchronized value equals Q SHALL clear its run counter to 0.
REQ-018 On a tick, a channel whose synchronized value differs from Q with run counter < FILTER_LEN-1 SHALL increment the counter.
REQ-019 On a tick, a channel whose synchronized value differs from Q with run counter == FILTER_LEN-1 SHALL invert Q, clear the counter, and assert rise or fall for exactly that one clock.
REQ-020 FILTER_LEN=1: Q SHALL take the synchronized value on every tick.
REQ-021 Latency (PRESCALE=1): D changed and held stable before edge 0 -> Q, pulse, and changed update at edge SYNC_STAGES+FILTER_LEN-1 (edge 5 for defaults).
REQ-022 Any single disagreeing sample within a run SHALL restart the run from 0 (no hysteresis credit).
REQ-023 rise, fall, changed SHALL be 0 on every clock without a Q transition, including all clocks with enable=0.
REQ-024 Channels SHALL be fully independent; simultaneous transitions on multiple channels SHALL each produce their own pulse in the same cycle, with a single-cycle changed.
REQ-025 Q SHALL never change other than via REQ-019 or reset.

Reset
REQ-026 While reset=1 at a rising edge: synchronizer flops and Q = INIT_LEVEL on all channels, run counters = 0, prescaler = 0, rise = fall = 0, changed = 0.
REQ-027 reset SHALL take priority over enable and over any pending transition; reset asserted mid-run SHALL discard the run and emit no pulse.
REQ-028 First tick after reset release: PRESCALE-1 clocks after the first non-reset edge (counting that edge as clock 0).

Verification (defaults unless stated: CHANNELS=4, SYNC_STAGES=2, FILTER_LEN=4, PRESCALE=1, INIT_LEVEL=0)
REQ-029 Reset, enable=1, D=4'b0001 held from before edge 0 -> Q=4'b0001 after edge 5; rise=4'b0001 and changed=1 for that one cycle only; fall=0 throughout.
REQ-030 Bounce on D[1]: high 3 clocks, low 1, high thereafter -> Q[1] stays 0 through the short burst; Q[1] rises exactly 5 edges after the final rising edge of D[1].
REQ-031 With Q=4'b0001, same clock D[0]->0 and D[2]->1 -> after 5 edges Q=4'b0100, fall=4'b0001, rise=4'b0100, changed=1, all for one cycle.
REQ-032 D[3] rises, enable dropped after 2 counted samples for 10 clocks, then restored -> Q[3] unchanged and no pulses while disabled; Q[3] rises after 2 further ticks.
REQ-033 Q=4'b1111, D held 4'b1111, reset pulsed one clock -> Q=4'b0000 after that edge, fall=0; Q re-rises 4'b1111 per REQ-021 with rise=4'b1111.
REQ-034 PRESCALE=3, D[0] rising held -> Q[0] rises only on the 4th consecutive tick seeing 1; no change on non-tick clocks; pulse width still one clock.
